pkt_ingress_ctrl: RTL and testbench
===================================

// Module: pkt_ingress_ctrl
// PURPOSE
//  Upstream stage of the convertible FIFO/SRAM packet buffer. Accepts the NetFPGA
//  64b data + 8b ctrl stream and frames it into 72b buffer words {ctrl,data}.
//  Generates write strobe, write address, first/last markers and block control
//  for the buffer. Holds off the network once one whole packet is stored, until
//  the processor side releases it.
// PARAMETERS
//  DATA_WIDTH  64   NetFPGA data word width
//  CTRL_WIDTH  8    NetFPGA ctrl word width
//  ADDR_WIDTH  8    buffer address width; MAX_WORDS = 2**ADDR_WIDTH
// PORTS
//  clk            in   1    single system clock
//  rst            in   1    synchronous reset, active-low
//  in_data        in   64   NetFPGA data word
//  in_ctrl        in   8    NetFPGA ctrl word (!=0 header/last, ==0 payload)
//  in_wr          in   1    word valid; accepted only when in_rdy=1
//  in_rdy         out  1    ready to accept a word from the network
//  fifo_din       out  72   {in_ctrl,in_data} registered, to buffer write data
//  fifo_wr        out  1    buffer write strobe (NetFPGA write)
//  fifo_waddr     out  8    buffer write address
//  net_allow      out  1    1 = network owns buffer write port (block when 0)
//  first_word     out  1    marks fifo_din as first word of packet
//  last_word      out  1    marks fifo_din as last word of packet
//  pkt_ready      out  1    level: a complete packet is held in the buffer
//  pkt_len        out  9    word count of held packet (1..MAX_WORDS)
//  pkt_release    in   1    1-cycle pulse: processor done, free buffer
//  pkt_drop       out  1    1-cycle pulse: oversize packet discarded
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE, in_rdy=1, net_allow=1, wptr=0,
//    fifo_wr/first_word/last_word/pkt_ready/pkt_drop=0, pkt_len=0, fifo_din=0.
//  - Accept = in_wr & in_rdy. in_wr while in_rdy=0 is ignored (no write).
//  - Latency: accepted word appears on fifo_din/fifo_wr/fifo_waddr 1 cycle later;
//    markers aligned to the same cycle as fifo_wr.
//  - Every packet is written from address 0; wptr increments per write, 8b wrap.
//  - FSM: IDLE, HEADER, PAYLOAD, HOLD, DROP.
//    IDLE:    accept ctrl!=0 -> write @0, first_word=1, ->HEADER.
//             accept ctrl==0 -> stray word, discarded, stay IDLE.
//    HEADER:  accept ctrl!=0 -> write; ctrl==0 -> write, ->PAYLOAD.
//    PAYLOAD: accept ctrl==0 -> write; ctrl!=0 -> write, last_word=1, ->HOLD.
//    HOLD:    in_rdy=0, net_allow=0, pkt_ready=1, pkt_len=words written.
//             pkt_release -> IDLE next cycle, in_rdy=net_allow=1, pkt_ready=0, wptr=0.
//    DROP:    in_rdy=1, no writes; stays until an accepted ctrl!=0 word that
//             follows at least one ctrl==0 word -> pkt_drop pulse, ->IDLE, wptr=0.
//  - in_rdy/net_allow drop in the cycle after the last word is accepted.
//  - Overflow: accepting a word with wptr=MAX_WORDS-1 that is not the last word
//    writes it, then ->DROP (no last_word). Exactly MAX_WORDS words ending
//    in a last word is legal, pkt_len=256.
//  - pkt_release outside HOLD is ignored. Release and new in_wr in the same
//    cycle: the release wins, and the word is not accepted (in_rdy was 0).
//  - Reset mid-packet: partial packet abandoned; no markers, no pkt_drop.
// STRUCTURE
//  - Shared include pkt_defs.vh: FSM state encodings, DATA/CTRL widths,
//    CTRL_PAYLOAD=8'h00.
//  - One sub-module: pkt_wptr_cnt (wptr + length counter, clear/inc/full flag).
//  - All outputs are registered; no combinational in->out paths.
// TESTING
//  - Reset: rst=0 for 2 cycles -> in_rdy=1, fifo_wr=0, pkt_ready=0, wptr=0.
//  - 4-word pkt (ctrl FF,00,00,01) -> fifo_wr at addr 0..3, first_word with addr 0,
//    last_word with addr 3, pkt_ready=1, pkt_len=4, in_rdy=0.
//  - HOLD then in_wr pulses -> no fifo_wr; pkt_release -> in_rdy=1 next cycle;
//    next pkt starts at addr 0.
//  - Stray ctrl=00 word in IDLE -> no fifo_wr, state stays IDLE.
//  - 300-word pkt -> 256 writes, no last_word, pkt_drop pulse after ctrl!=0 tail,
//    in_rdy=1 throughout; next pkt written from addr 0.
//  - rst=0 during PAYLOAD at wptr=5 -> IDLE, wptr=0, pkt_drop=0, pkt_ready=0.

Source files
------------

// File: rtl/pkt_ingress_ctrl_pkg.sv
// Shared types and constants for the packet ingress controller slice.
// Imported by the framing controller and its write-pointer counter.
package pkt_ingress_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_CTRL_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    // A NetFPGA ctrl value of zero marks a payload word.
    localparam logic [DEF_CTRL_WIDTH-1:0] CTRL_PAYLOAD = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_HOLD,
        ST_DROP
    } pkt_state_t;

endpackage

// File: rtl/pkt_wptr_cnt.sv
// Buffer write pointer and packet length counter.
// The low ADDR_WIDTH bits address the buffer; the extra bit lets a full buffer report its length.
module pkt_wptr_cnt
    import pkt_ingress_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_ONE;
        end
    end

    assign wptr = count[ADDR_WIDTH-1:0];
    assign full = &wptr;

endmodule

// File: rtl/pkt_ingress_ctrl.sv
// Frames the NetFPGA ctrl/data stream into buffer words and holds off the network
// while one complete packet sits in the buffer awaiting release by the processor.
module pkt_ingress_ctrl
    import pkt_ingress_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_din,
    output logic                             fifo_wr,
    output logic [ADDR_WIDTH-1:0]            fifo_waddr,
    output logic                             net_allow,
    output logic                             first_word,
    output logic                             last_word,
    output logic                             pkt_ready,
    output logic [ADDR_WIDTH:0]              pkt_len,
    input  logic                             pkt_release,
    output logic                             pkt_drop
);

    localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

    pkt_state_t state, next_state;

    logic                  accept;
    logic                  is_payload;
    logic                  do_write;
    logic                  mark_first;
    logic                  mark_last;
    logic                  end_drop;
    logic                  drop_seen_pl;
    logic                  cnt_clr;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  wptr_full;

    pkt_wptr_cnt #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (do_write),
        .wptr  (wptr),
        .count (wr_count),
        .full  (wptr_full)
    );

    always_comb begin
        next_state = state;
        accept     = in_wr & in_rdy;
        is_payload = (in_ctrl == CTRL_WIDTH'(CTRL_PAYLOAD));
        do_write   = 1'b0;
        mark_first = 1'b0;
        mark_last  = 1'b0;
        end_drop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && !is_payload) begin
                    do_write   = 1'b1;
                    mark_first = 1'b1;
                    next_state = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    do_write = 1'b1;
                    if (wptr_full)
                        next_state = ST_DROP;
                    else if (is_payload)
                        next_state = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // A terminating word is legal even in the last buffer slot.
                if (accept) begin
                    do_write = 1'b1;
                    if (!is_payload) begin
                        mark_last  = 1'b1;
                        next_state = ST_HOLD;
                    end else if (wptr_full) begin
                        next_state = ST_DROP;
                    end
                end
            end
            ST_HOLD: begin
                if (pkt_release)
                    next_state = ST_IDLE;
            end
            ST_DROP: begin
                if (accept && !is_payload && drop_seen_pl) begin
                    end_drop   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        cnt_clr = (next_state == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // The overflowing word itself counts as the payload that precedes a discard tail.
    always_ff @(posedge clk) begin
        if (!rst)
            drop_seen_pl <= 1'b0;
        else if (state != ST_DROP)
            drop_seen_pl <= is_payload;
        else if (accept && is_payload)
            drop_seen_pl <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_din   <= '0;
            fifo_wr    <= 1'b0;
            fifo_waddr <= '0;
            first_word <= 1'b0;
            last_word  <= 1'b0;
            pkt_drop   <= 1'b0;
            in_rdy     <= 1'b1;
            net_allow  <= 1'b1;
            pkt_ready  <= 1'b0;
            pkt_len    <= '0;
        end else begin
            fifo_wr    <= do_write;
            first_word <= mark_first;
            last_word  <= mark_last;
            pkt_drop   <= end_drop;
            if (do_write) begin
                fifo_din   <= {in_ctrl, in_data};
                fifo_waddr <= wptr;
            end
            in_rdy    <= (next_state != ST_HOLD);
            net_allow <= (next_state != ST_HOLD);
            pkt_ready <= (next_state == ST_HOLD);
            if (mark_last)
                pkt_len <= wr_count + LEN_ONE;
            else if (next_state != ST_HOLD)
                pkt_len <= '0;
        end
    end

endmodule

// File: tb/tb_pkt_ingress_ctrl.sv
// Randomized bench for pkt_ingress_ctrl; a packet-level model predicts every buffer write,
// drop pulse and hold/ready level, and a monitor records what the design actually writes.
module tb_pkt_ingress_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [71:0] fifo_din;
    logic        fifo_wr;
    logic [7:0]  fifo_waddr;
    logic        net_allow;
    logic        first_word;
    logic        last_word;
    logic        pkt_ready;
    logic [8:0]  pkt_len;
    logic        pkt_release = 1'b0;
    logic        pkt_drop;

    always #5 clk = ~clk;

    pkt_ingress_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .fifo_din    (fifo_din),
        .fifo_wr     (fifo_wr),
        .fifo_waddr  (fifo_waddr),
        .net_allow   (net_allow),
        .first_word  (first_word),
        .last_word   (last_word),
        .pkt_ready   (pkt_ready),
        .pkt_len     (pkt_len),
        .pkt_release (pkt_release),
        .pkt_drop    (pkt_drop)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [71:0] din;
        logic        first;
        logic        last;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  obs_drops, exp_drops, stray_marks, lvl_bad;
    int  checks = 0;
    int  passes = 0;

    // Packet-level reference state: holding a packet, discarding one, inside one.
    bit  m_hold, m_drop, m_started, m_seen_pl;
    int  m_n, m_len;

    always @(negedge clk) begin
        if (fifo_wr === 1'b1)
            obs_q.push_back('{addr: fifo_waddr, din: fifo_din, first: first_word, last: last_word});
        else if (first_word === 1'b1 || last_word === 1'b1)
            stray_marks++;
        if (pkt_drop === 1'b1)
            obs_drops++;
    end

    task automatic model_reset();
        m_hold = 0; m_drop = 0; m_started = 0; m_seen_pl = 0;
        m_n = 0; m_len = 0;
    endtask

    task automatic clear_scoreboard();
        obs_q.delete();
        exp_q.delete();
        obs_drops = 0; exp_drops = 0; stray_marks = 0; lvl_bad = 0;
    endtask

    task automatic model_word(input logic [7:0] ctrl, input logic [63:0] data);
        bit  pl, last;
        wr_t w;
        pl = (ctrl == 8'h00);
        if (m_drop) begin
            if (pl) m_seen_pl = 1;
            else if (m_seen_pl) begin
                m_drop = 0; m_n = 0; exp_drops++;
            end
        end else if (!m_started) begin
            if (!pl) begin
                w = '{addr: 8'd0, din: {ctrl, data}, first: 1'b1, last: 1'b0};
                exp_q.push_back(w);
                m_n = 1; m_started = 1; m_seen_pl = 0;
            end
        end else begin
            last = !pl && m_seen_pl;
            w = '{addr: 8'(m_n % 256), din: {ctrl, data}, first: 1'b0, last: last};
            exp_q.push_back(w);
            m_n++;
            if (last) begin
                m_hold = 1; m_len = m_n; m_started = 0;
            end else if (m_n == 256) begin
                m_drop = 1; m_started = 0; m_seen_pl = pl;
            end else if (pl) begin
                m_seen_pl = 1;
            end
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own hold state.
    task automatic step(input logic wr, input logic [7:0] ctrl, input logic [63:0] data,
                        input logic rel, input logic rst_v);
        bit acc;
        rst = rst_v; in_wr = wr; in_ctrl = ctrl; in_data = data; pkt_release = rel;
        @(posedge clk);
        if (!rst_v) begin
            model_reset();
        end else begin
            acc = wr && !m_hold;
            if (m_hold && rel) begin
                m_hold = 0; m_len = 0;
            end
            if (acc) model_word(ctrl, data);
        end
        @(negedge clk);
        #1;
        if (in_rdy !== !m_hold || net_allow !== !m_hold || pkt_ready !== m_hold
            || pkt_len !== 9'(m_len))
            lvl_bad++;
        in_wr = 1'b0; pkt_release = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_gaps(input int gap_pct);
        while ($urandom_range(0, 99) < gap_pct)
            step(1'b0, 8'($urandom), rnd64(), 1'b0, 1'b1);
    endtask

    task automatic send_pkt(input int n_hdr, input int n_pl, input int gap_pct);
        for (int i = 0; i < n_hdr; i++) begin
            idle_gaps(gap_pct);
            step(1'b1, 8'($urandom_range(1, 255)), rnd64(), 1'b0, 1'b1);
        end
        for (int i = 0; i < n_pl; i++) begin
            idle_gaps(gap_pct);
            step(1'b1, 8'h00, rnd64(), 1'b0, 1'b1);
        end
        idle_gaps(gap_pct);
        step(1'b1, 8'($urandom_range(1, 255)), rnd64(), 1'b0, 1'b1);
    endtask

    // Network keeps offering words while held; the final cycle pairs release with in_wr.
    task automatic do_release(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++)
            step(1'($urandom), 8'($urandom), rnd64(), 1'b0, 1'b1);
        step(1'b1, 8'($urandom_range(1, 255)), rnd64(), 1'b1, 1'b1);
    endtask

    function automatic int q_diffs();
        int d;
        d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                          : exp_q.size() - obs_q.size();
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        model_reset();
        step(1'b0, 8'h00, '0, 1'b0, 1'b0);
        step(1'b0, 8'h00, '0, 1'b0, 1'b0);
        checks++; if (in_rdy !== 1'b1) $display("[TB] FAIL reset_in_rdy got %b want 1", in_rdy); else passes++;
        checks++; if (fifo_wr !== 1'b0) $display("[TB] FAIL reset_fifo_wr got %b want 0", fifo_wr); else passes++;
        checks++; if (pkt_ready !== 1'b0) $display("[TB] FAIL reset_pkt_ready got %b want 0", pkt_ready); else passes++;
        checks++; if (net_allow !== 1'b1) $display("[TB] FAIL reset_net_allow got %b want 1", net_allow); else passes++;
        checks++; if (pkt_len !== 9'd0) $display("[TB] FAIL reset_pkt_len got %0d want 0", pkt_len); else passes++;
        checks++; if (fifo_waddr !== 8'd0 || fifo_din !== 72'd0)
            $display("[TB] FAIL reset_fifo_bus got addr %0d din %h want 0/0", fifo_waddr, fifo_din); else passes++;
        step(1'b0, 8'h00, '0, 1'b0, 1'b1);
        clear_scoreboard();
    endtask

    task automatic test_basic_packet();
        clear_scoreboard();
        step(1'b1, 8'hFF, rnd64(), 1'b0, 1'b1);
        step(1'b1, 8'h00, rnd64(), 1'b0, 1'b1);
        step(1'b1, 8'h00, rnd64(), 1'b0, 1'b1);
        step(1'b1, 8'h01, rnd64(), 1'b0, 1'b1);
        checks++; if (obs_q.size() !== 4) $display("[TB] FAIL basic_writes got %0d want 4", obs_q.size()); else passes++;
        checks++; if (q_diffs() !== 0) $display("[TB] FAIL basic_contents got %0d bad words want 0", q_diffs()); else passes++;
        checks++; if (pkt_ready !== 1'b1 || pkt_len !== 9'd4)
            $display("[TB] FAIL basic_hold got ready %b len %0d want 1/4", pkt_ready, pkt_len); else passes++;
        checks++; if (in_rdy !== 1'b0 || net_allow !== 1'b0)
            $display("[TB] FAIL basic_block got rdy %b allow %b want 0/0", in_rdy, net_allow); else passes++;
    endtask

    task automatic test_hold_release();
        int n0, nh, np;
        n0 = obs_q.size();
        do_release(5);
        checks++; if (obs_q.size() !== n0) $display("[TB] FAIL hold_no_write got %0d writes want 0", obs_q.size() - n0); else passes++;
        checks++; if (in_rdy !== 1'b1 || pkt_ready !== 1'b0)
            $display("[TB] FAIL release_levels got rdy %b ready %b want 1/0", in_rdy, pkt_ready); else passes++;
        clear_scoreboard();
        nh = $urandom_range(1, 3); np = $urandom_range(1, 20);
        send_pkt(nh, np, 25);
        checks++; if (q_diffs() !== 0) $display("[TB] FAIL second_pkt_contents got %0d bad words want 0", q_diffs()); else passes++;
        checks++; if (pkt_len !== 9'(nh + np + 1)) $display("[TB] FAIL second_pkt_len got %0d want %0d", pkt_len, nh + np + 1); else passes++;
        do_release($urandom_range(0, 4));
    endtask

    task automatic test_stray();
        clear_scoreboard();
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h00, rnd64(), 1'b0, 1'b1);
        checks++; if (obs_q.size() !== 0) $display("[TB] FAIL stray_no_write got %0d want 0", obs_q.size()); else passes++;
        send_pkt(1, 2, 0);
        checks++; if (q_diffs() !== 0 || obs_q.size() !== 4)
            $display("[TB] FAIL stray_then_pkt got %0d bad words, %0d writes want 0/4", q_diffs(), obs_q.size()); else passes++;
        do_release(1);
    endtask

    task automatic test_oversize();
        int lasts;
        clear_scoreboard();
        send_pkt(1, 298, 10);
        lasts = 0;
        foreach (obs_q[i]) if (obs_q[i].last) lasts++;
        checks++; if (obs_q.size() !== 256) $display("[TB] FAIL oversize_writes got %0d want 256", obs_q.size()); else passes++;
        checks++; if (q_diffs() !== 0) $display("[TB] FAIL oversize_contents got %0d bad words want 0", q_diffs()); else passes++;
        checks++; if (lasts !== 0) $display("[TB] FAIL oversize_last got %0d want 0", lasts); else passes++;
        checks++; if (obs_drops !== 1) $display("[TB] FAIL oversize_drop got %0d pulses want 1", obs_drops); else passes++;
        checks++; if (lvl_bad !== 0) $display("[TB] FAIL oversize_rdy got %0d bad cycles want 0", lvl_bad); else passes++;
        clear_scoreboard();
        send_pkt(2, 3, 0);
        checks++; if (q_diffs() !== 0 || pkt_len !== 9'd6)
            $display("[TB] FAIL after_drop_pkt got %0d bad words len %0d want 0/6", q_diffs(), pkt_len); else passes++;
        do_release(2);
    endtask

    task automatic test_full_256();
        clear_scoreboard();
        send_pkt(1, 254, 5);
        checks++; if (pkt_len !== 9'd256 || pkt_ready !== 1'b1)
            $display("[TB] FAIL full_len got %0d ready %b want 256/1", pkt_len, pkt_ready); else passes++;
        checks++; if (obs_q.size() !== 256 || q_diffs() !== 0)
            $display("[TB] FAIL full_contents got %0d writes %0d bad want 256/0", obs_q.size(), q_diffs()); else passes++;
        if (obs_q.size() == 256) begin
            checks++; if (obs_q[255].last !== 1'b1 || obs_q[255].addr !== 8'd255)
                $display("[TB] FAIL full_last got last %b addr %0d want 1/255", obs_q[255].last, obs_q[255].addr); else passes++;
        end
        do_release(3);
    endtask

    task automatic test_reset_mid();
        clear_scoreboard();
        step(1'b1, 8'hA5, rnd64(), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'h00, rnd64(), 1'b0, 1'b1);
        step(1'b0, 8'h00, '0, 1'b0, 1'b0);
        checks++; if (pkt_drop !== 1'b0 || pkt_ready !== 1'b0 || in_rdy !== 1'b1)
            $display("[TB] FAIL midreset_levels got drop %b ready %b rdy %b want 0/0/1", pkt_drop, pkt_ready, in_rdy); else passes++;
        obs_q.delete(); exp_q.delete();
        send_pkt(1, 1, 0);
        checks++; if (q_diffs() !== 0 || obs_drops !== 0 || stray_marks !== 0)
            $display("[TB] FAIL midreset_next got %0d bad words %0d drops %0d stray want 0/0/0",
                     q_diffs(), obs_drops, stray_marks); else passes++;
        do_release(1);
    endtask

    task automatic test_back_to_back();
        clear_scoreboard();
        for (int p = 0; p < 12; p++) begin
            for (int s = $urandom_range(0, 2); s > 0; s--)
                step(1'b1, 8'h00, rnd64(), 1'b0, 1'b1);
            send_pkt($urandom_range(1, 3), $urandom_range(1, 40), 30);
            do_release($urandom_range(0, 6));
        end
        checks++; if (q_diffs() !== 0) $display("[TB] FAIL random_contents got %0d bad words want 0", q_diffs()); else passes++;
        checks++; if (exp_q.size() == 0 || obs_q.size() !== exp_q.size())
            $display("[TB] FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
        checks++; if (obs_drops !== exp_drops) $display("[TB] FAIL random_drops got %0d want %0d", obs_drops, exp_drops); else passes++;
        checks++; if (lvl_bad !== 0) $display("[TB] FAIL random_levels got %0d bad cycles want 0", lvl_bad); else passes++;
        checks++; if (stray_marks !== 0) $display("[TB] FAIL random_markers got %0d stray want 0", stray_marks); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_hold_release();
        test_stray();
        test_oversize();
        test_full_256();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
